mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Two-master arbiter that shares the CPU's single Avalon-style memory bus between the instruction-fetch port (I) and the load/store port (D) of the multicycle core. It sits between the core's internal ports and the top-level `address/read/write/waitrequest/byteenable/writedata/readdata` bus. It grants exactly one master per transfer, holds the grant through memory wait states, and routes `readdata` and `waitrequest` back to the granted master only.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`

- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high
- `i_address`  in  ADDR_W  I-port address
- `i_read`  in  1  I-port read request; I-port is read-only
- `i_byteenable`  in  DATA_W/8  I-port lane enables
- `i_readdata`  out  DATA_W  I-port read data
- `i_waitrequest`  out  1  I-port stall
- `d_address`  in  ADDR_W  D-port address
- `d_read`, `d_write`  in  1 each  D-port requests
- `d_byteenable`  in  DATA_W/8  D-port lane enables
- `d_writedata`  in  DATA_W  D-port write data
- `d_readdata`  out  DATA_W  D-port read data
- `d_waitrequest`  out  1  D-port stall
- `address`, `read`, `write`, `byteenable`, `writedata`  out  ADDR_W/1/1/DATA_W/8/DATA_W  memory-side command
- `readdata`  in  DATA_W  memory read data
- `waitrequest`  in  1  memory stall
- `busy`  out  1  high in any non-IDLE state

## Operation
- States: IDLE, GNT_I, GNT_D.
- IDLE: no memory command driven (`read=write=0`, `address/byteenable/writedata` = 0). If any request is pending, a grant is chosen and the next state is GNT_I or GNT_D.
- Arbitration in IDLE without the macro: fixed priority, D over I.
- GNT_x: memory command outputs are driven combinationally from master x's inputs. `x_waitrequest = waitrequest`. `x_readdata = readdata`. Transfer completes in any cycle with `waitrequest=0`, and the next state is IDLE.
- Non-granted master: `waitrequest=1`, `readdata=0`.
- A master must hold its request and operands stable until it sees `waitrequest=0`. The arbiter does not latch operands.
- If `d_read` and `d_write` are both high, the write wins and `read` is driven 0.
- If the granted master drops its request before completion (protocol violation), the arbiter returns to IDLE next cycle without completing the transfer.
- In IDLE, both `i_waitrequest` and `d_waitrequest` are 1.

## Timing
- Reset: while `reset=1`, every output is forced combinationally to its idle value: `read=write=0`, buses 0, both `*_waitrequest=1`, `busy=0`. State is IDLE after the edge.
- Reset mid-transfer aborts the transfer. The memory command is dropped in the same cycle.
- Latency: request sampled in IDLE at edge N. Command appears on memory from cycle N+1. With zero memory wait states the master completes in cycle N+1, which is 2 cycles per transfer.
- Each memory wait cycle adds 1 cycle. A grant is never revoked while `waitrequest=1`.
- Mandatory 1-cycle IDLE bubble between transfers, so maximum throughput is 1 transfer per 2 cycles.
- Simultaneous I and D requests in IDLE are resolved by the arbitration rule. The loser waits at least 2 cycles.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: a 1-bit `last_grant` register (reset value: I) is updated on each completed transfer. On a simultaneous request, the grant goes to the master not equal to `last_grant`. With a single requester, that requester wins.
  - Undefined: fixed D-over-I priority and no `last_grant` register.

## Test plan
- Reset held 2 cycles with `d_write=1` -> `write=0`, `busy=0`, both waitrequests 1. After release, the D write reaches memory 1 cycle later.
- I read only, `i_address=0xBFC00000`, memory returns `0x8C020004` with 0 wait states -> `read=1` in cycle 1, `i_readdata=0x8C020004`, `i_waitrequest=0` in cycle 1, IDLE in cycle 2.
- D write `d_address=0x10`, `d_byteenable=4'b0011`, `d_writedata=0xDEADBEEF`, memory waitrequest high 5 cycles -> `write`, `address=0x10`, `byteenable=0011` held 6 cycles. `d_waitrequest` falls only in the 6th cycle.
- Simultaneous I read and D read, back-to-back for 4 transfers:
  - Without the macro: order D,D,D,D while D keeps requesting; I starves.
  - With the macro: order D,I,D,I.
- D asserts `d_read` and `d_write` together -> memory sees `write=1`, `read=0`.
- Reset asserted in GNT_D during a wait state -> same cycle `write=0`. Next cycle IDLE. A pending I request is granted after reset falls.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter for the shared memory bus.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces fixed D-over-I priority with round-robin.
module mips_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  input  logic [DATA_W/8-1:0] i_byteenable,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_waitrequest,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_waitrequest,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                waitrequest,
  output logic                busy
);

  // state   | meaning
  // IDLE    | no command on memory, choosing next grant
  // GNT_I   | memory bus owned by instruction-fetch port
  // GNT_D   | memory bus owned by load/store port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   d_req;
  logic   pick_d;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_grant: 0 = I, 1 = D
  logic last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (!waitrequest) begin
      if (state == GNT_I && i_read)
        last_grant <= 1'b0;
      else if (state == GNT_D && d_req)
        last_grant <= 1'b1;
    end
  end

  always_comb begin
    if (d_req && i_read)
      pick_d = ~last_grant;
    else
      pick_d = d_req;
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d)
          state_nxt = GNT_D;
        else if (i_read)
          state_nxt = GNT_I;
      end
      // A dropped request also returns to IDLE (abandoned transfer).
      GNT_I: if (!waitrequest || !i_read) state_nxt = IDLE;
      GNT_D: if (!waitrequest || !d_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    byteenable    = '0;
    writedata     = '0;
    i_readdata    = '0;
    d_readdata    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    busy          = 1'b0;
    if (!reset) begin
      case (state)
        GNT_I: begin
          address       = i_address;
          read          = i_read;
          byteenable    = i_byteenable;
          i_readdata    = readdata;
          i_waitrequest = waitrequest;
          busy          = 1'b1;
        end
        GNT_D: begin
          address       = d_address;
          write         = d_write;
          read          = d_read & ~d_write;
          byteenable    = d_byteenable;
          writedata     = d_writedata;
          d_readdata    = readdata;
          d_waitrequest = waitrequest;
          busy          = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed table-driven bench for mips_mem_arbiter plus an arbitration-order sequence.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read;
  logic [3:0]  i_byteenable;
  logic [31:0] i_readdata;
  logic        i_waitrequest;
  logic [31:0] d_address;
  logic        d_read, d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata;
  logic        d_waitrequest;
  logic [31:0] address;
  logic        read, write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_byteenable(i_byteenable),
    .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_byteenable(d_byteenable), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .busy(busy)
  );

  typedef struct {
    logic        rst, i_rd;
    logic [31:0] i_addr;
    logic        d_rd, d_wr;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wd, m_rdata;
    logic        m_wait;
    logic        e_rd, e_wr;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ird, e_drd;
    logic        e_iw, e_dw, e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic [199:0] act_b, exp_b;
  localparam logic [1:0] G_I = 2'd1, G_D = 2'd2;
  logic [1:0] order[4];
  logic [1:0] exp_order[4];
  int ngr;

  initial begin
    reset = 1'b1; i_address = '0; i_read = 1'b0; i_byteenable = 4'hF;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_byteenable = '0;
    d_writedata = '0; readdata = '0; waitrequest = 1'b0;

    // reset held two cycles with a pending D write, then the write goes out
    vecs.push_back('{1,0,0, 0,1,32'h10,4'h3,32'hDEADBEEF, 0,0, 0,0,0,0,0,0,0, 1,1,0});
    vecs.push_back('{1,0,0, 0,1,32'h10,4'h3,32'hDEADBEEF, 0,0, 0,0,0,0,0,0,0, 1,1,0});
    vecs.push_back('{0,0,0, 0,1,32'h10,4'h3,32'hDEADBEEF, 0,0, 0,0,0,0,0,0,0, 1,1,0});
    vecs.push_back('{0,0,0, 0,1,32'h10,4'h3,32'hDEADBEEF, 0,0, 0,1,32'h10,4'h3,32'hDEADBEEF,0,0, 1,0,1});
    vecs.push_back('{0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0, 1,1,0});
    // I read, zero wait states
    vecs.push_back('{0,1,32'hBFC00000, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0, 1,1,0});
    vecs.push_back('{0,1,32'hBFC00000, 0,0,0,0,0, 32'h8C020004,0, 1,0,32'hBFC00000,4'hF,0,32'h8C020004,0, 0,1,1});
    vecs.push_back('{0,0,0, 0,0,0,0,0, 32'h8C020004,0, 0,0,0,0,0,0,0, 1,1,0});
    // D write with five memory wait cycles
    vecs.push_back('{0,0,0, 0,1,32'h10,4'h3,32'hDEADBEEF, 0,1, 0,0,0,0,0,0,0, 1,1,0});
    for (int k = 0; k < 5; k++)
      vecs.push_back('{0,0,0, 0,1,32'h10,4'h3,32'hDEADBEEF, 0,1, 0,1,32'h10,4'h3,32'hDEADBEEF,0,0, 1,1,1});
    vecs.push_back('{0,0,0, 0,1,32'h10,4'h3,32'hDEADBEEF, 0,0, 0,1,32'h10,4'h3,32'hDEADBEEF,0,0, 1,0,1});
    vecs.push_back('{0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0, 1,1,0});
    // read+write together: write wins
    vecs.push_back('{0,0,0, 1,1,32'h20,4'hF,32'h12345678, 0,0, 0,0,0,0,0,0,0, 1,1,0});
    vecs.push_back('{0,0,0, 1,1,32'h20,4'hF,32'h12345678, 0,0, 0,1,32'h20,4'hF,32'h12345678,0,0, 1,0,1});
    vecs.push_back('{0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0, 1,1,0});
    // reset during a D wait state, then pending I is served
    vecs.push_back('{0,0,0, 0,1,32'h40,4'hF,32'hAAAA5555, 0,1, 0,0,0,0,0,0,0, 1,1,0});
    vecs.push_back('{0,1,32'h100, 0,1,32'h40,4'hF,32'hAAAA5555, 0,1, 0,1,32'h40,4'hF,32'hAAAA5555,0,0, 1,1,1});
    vecs.push_back('{1,1,32'h100, 0,1,32'h40,4'hF,32'hAAAA5555, 0,1, 0,0,0,0,0,0,0, 1,1,0});
    vecs.push_back('{0,1,32'h100, 0,0,0,0,0, 0,1, 0,0,0,0,0,0,0, 1,1,0});
    vecs.push_back('{0,1,32'h100, 0,0,0,0,0, 32'hCAFEF00D,0, 1,0,32'h100,4'hF,0,32'hCAFEF00D,0, 0,1,1});
    vecs.push_back('{0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0, 1,1,0});
    // D drops its read mid-wait: abandoned, back to IDLE
    vecs.push_back('{0,0,0, 1,0,32'h80,4'hF,0, 0,1, 0,0,0,0,0,0,0, 1,1,0});
    vecs.push_back('{0,0,0, 1,0,32'h80,4'hF,0, 32'h55,1, 1,0,32'h80,4'hF,0,0,32'h55, 1,1,1});
    vecs.push_back('{0,0,0, 0,0,32'h80,4'hF,0, 32'h55,1, 0,0,32'h80,4'hF,0,0,32'h55, 1,1,1});
    vecs.push_back('{0,0,0, 0,0,0,0,0, 32'h55,1, 0,0,0,0,0,0,0, 1,1,0});

    foreach (vecs[k]) begin
      @(negedge clk);
      reset = vecs[k].rst; i_read = vecs[k].i_rd; i_address = vecs[k].i_addr;
      d_read = vecs[k].d_rd; d_write = vecs[k].d_wr; d_address = vecs[k].d_addr;
      d_byteenable = vecs[k].d_be; d_writedata = vecs[k].d_wd;
      readdata = vecs[k].m_rdata; waitrequest = vecs[k].m_wait;
      #1;
      act_b = {read, write, address, byteenable, writedata, i_readdata, d_readdata,
               i_waitrequest, d_waitrequest, busy};
      exp_b = {vecs[k].e_rd, vecs[k].e_wr, vecs[k].e_addr, vecs[k].e_be, vecs[k].e_wd,
               vecs[k].e_ird, vecs[k].e_drd, vecs[k].e_iw, vecs[k].e_dw, vecs[k].e_busy};
      check($sformatf("vec%0d", k), act_b, exp_b);
    end

    // both masters request continuously: record the grant order of four transfers
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{G_D, G_I, G_D, G_I};
`else
    exp_order = '{G_D, G_D, G_D, G_D};
`endif
    ngr = 0;
    @(negedge clk);
    i_read = 1'b1; i_address = 32'h200; d_read = 1'b1; d_write = 1'b0;
    d_address = 32'h300; d_byteenable = 4'hF; readdata = 32'h77; waitrequest = 1'b0;
    for (int c = 0; c < 20 && ngr < 4; c++) begin
      #1;
      if (!d_waitrequest) begin order[ngr] = G_D; ngr++; end
      else if (!i_waitrequest) begin order[ngr] = G_I; ngr++; end
      @(negedge clk);
    end
    check("arb_grant_count", 200'(ngr), 200'(4));
    for (int k = 0; k < 4; k++)
      check($sformatf("arb_order%0d", k), (k < ngr) ? 200'(order[k]) : 200'(0), 200'(exp_order[k]));

    i_read = 1'b0; d_read = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
